// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the logic that arbitrates access to it:
// opcode width, opcode values and the arbiter sequencing states.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Opcodes understood by the ALU; ADD and SUB fold ALUFlagIn in as carry/borrow.
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'h0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'h1;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'h2;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'h3;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 4'h4;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant. Purely combinational; the caller owns the
// priority register and flips it after each completed operation.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  // A lone requester wins outright; on a tie the priority bit decides.
  always_comb begin
    gnt_vld = |req;
    gnt_idx = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = prio;
    end else if (req[1]) begin
      gnt_idx = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters. Each granted operation walks
// IDLE (accept) -> EXEC (ALU evaluates) -> RESP (hold result until consumed).
// A carry register per requester lets each one chain multi-word arithmetic.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int n = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [n-1:0]          req0_a,
  input  logic [n-1:0]          req0_b,
  input  logic [n-1:0]          req1_a,
  input  logic [n-1:0]          req1_b,
  input  logic [ALU_CTRL_W-1:0] req0_ctrl,
  input  logic [ALU_CTRL_W-1:0] req1_ctrl,
  input  logic [1:0]            req_use_carry,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [n-1:0]          rsp_result,
  output logic                  rsp_c,
  output logic                  rsp_z,
  output logic [n-1:0]          alu_a,
  output logic [n-1:0]          alu_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  alu_flagin,
  input  logic [n-1:0]          alu_result,
  input  logic                  alu_c,
  input  logic                  alu_z
);

  arb_state_e            state_q, state_d;
  logic                  prio_q, prio_d;
  logic                  owner_q, owner_d;
  logic [1:0]            carry_q, carry_d;
  logic [n-1:0]          a_q, a_d;
  logic [n-1:0]          b_q, b_d;
  logic [ALU_CTRL_W-1:0] ctrl_q, ctrl_d;
  logic                  flagin_q, flagin_d;
  logic [n-1:0]          res_q, res_d;
  logic                  c_q, c_d;
  logic                  z_q, z_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic                  gnt_vld;
  logic                  gnt_idx;
  logic                  accept;

  rr_arb2 u_rr_arb2 (
    .req     (req_valid),
    .prio    (prio_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Ready only in IDLE, only to the granted requester, and never while reset is held.
  always_comb begin
    req_ready = 2'b00;
    if ((state_q == IDLE) && gnt_vld && rst_n) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign accept = |req_ready;

  // Next-state and datapath register updates for the accept/execute/respond sequence.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    flagin_d    = flagin_q;
    res_d       = res_q;
    c_d         = c_q;
    z_d         = z_q;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = gnt_idx;
          a_d     = gnt_idx ? req1_a : req0_a;
          b_d     = gnt_idx ? req1_b : req0_b;
          ctrl_d  = gnt_idx ? req1_ctrl : req0_ctrl;
          // carry[owner] cannot change between accept and EXEC, so the flag-in
          // is resolved here and alu_flagin stays a plain register output.
          flagin_d = req_use_carry[gnt_idx] & carry_q[gnt_idx];
          state_d  = EXEC;
        end
      end
      EXEC: begin
        res_d                = alu_result;
        c_d                  = alu_c;
        z_d                  = alu_z;
        carry_d[owner_q]     = alu_c;
        rsp_valid_d          = 2'b00;
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = 2'b00;
          prio_d      = ~owner_q;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      carry_q     <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      flagin_q    <= 1'b0;
      res_q       <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      flagin_q    <= flagin_d;
      res_q       <= res_d;
      c_q         <= c_d;
      z_q         <= z_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = ctrl_q;
  assign alu_flagin = flagin_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = res_q;
  assign rsp_c      = c_q;
  assign rsp_z      = z_q;

endmodule
